// File: rtl/mem_bank_2rw_ctrl_pkg.sv
// Shared constants and types for the 2RW bank controller and its client interface.
package mem_bank_2rw_ctrl_pkg;

  localparam int MEM_REG_DEPTH = 4;
  localparam int MEM_REG_WIDTH = 64;
  localparam int MEM_ADDR_W    = $clog2(MEM_REG_DEPTH);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  // True when two write requests land on the same entry and the bank would drop port 1.
  function automatic logic same_addr_dual_write(
    input logic                  wmode_a,
    input logic                  wmode_b,
    input logic [MEM_ADDR_W-1:0] addr_a,
    input logic [MEM_ADDR_W-1:0] addr_b
  );
    return wmode_a & wmode_b & (addr_a == addr_b);
  endfunction

endpackage

// File: rtl/mem_bank_2rw_ctrl_if.sv
// One client port of the bank controller: request channel plus read-response channel.
interface mem_client_if
  import mem_bank_2rw_ctrl_pkg::*;
#(
  parameter int AW = MEM_ADDR_W,
  parameter int DW = MEM_REG_WIDTH
);

  logic          req_valid;
  logic          req_ready;
  logic          req_wmode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wmode, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wmode, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_bank_2rw_ctrl_rsp_slot.sv
// One-entry read-response register: loads on a read fire, holds data stable until taken.
// Latency 1 cycle from load to valid; a load in the same cycle as a take replaces the entry.
module mem_rsp_slot #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_bank_2rw_ctrl.sv
// Two-client controller for a 2RW bank with async read: clears the bank after reset, then
// forwards requests (1-cycle read latency); port 1 stalls a cycle on a same-address dual write.
module mem_bank_2rw_ctrl
  import mem_bank_2rw_ctrl_pkg::*;
#(
  parameter  int REG_DEPTH = MEM_REG_DEPTH,
  parameter  int REG_WIDTH = MEM_REG_WIDTH,
  localparam int AW        = $clog2(REG_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_client_if.slave          p0,
  mem_client_if.slave          p1,
  output logic                 RW0_clk,
  output logic                 RW0_wmode,
  output logic [AW-1:0]        RW0_addr,
  output logic [REG_WIDTH-1:0] RW0_wdata,
  input  logic [REG_WIDTH-1:0] RW0_rdata,
  output logic                 RW1_clk,
  output logic                 RW1_wmode,
  output logic [AW-1:0]        RW1_addr,
  output logic [REG_WIDTH-1:0] RW1_wdata,
  input  logic [REG_WIDTH-1:0] RW1_rdata,
  output logic                 init_done
);

  mem_state_e           state;
  logic [AW-1:0]        init_cnt;
  logic                 run;
  logic                 p0_ready, p1_ready;
  logic                 p0_fire, p1_fire;
  logic                 conflict;
  logic                 p0_rsp_vld, p1_rsp_vld;
  logic [REG_WIDTH-1:0] p0_rsp_dat, p1_rsp_dat;

  assign RW0_clk = clock;
  assign RW1_clk = clock;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == AW'(REG_DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          init_cnt  <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Gating with reset keeps a request from being accepted in the cycle reset is applied.
  assign run = (state == RUN) & ~reset;

  assign p0_ready = run & (p0.req_wmode | ~p0_rsp_vld | p0.rsp_ready);
  assign p0_fire  = p0.req_valid & p0_ready;

  assign conflict = p0_fire & p1.req_valid &
                    same_addr_dual_write(p0.req_wmode, p1.req_wmode, p0.req_addr, p1.req_addr);

  assign p1_ready = run & (p1.req_wmode | ~p1_rsp_vld | p1.rsp_ready) & ~conflict;
  assign p1_fire  = p1.req_valid & p1_ready;

  assign p0.req_ready = p0_ready;
  assign p1.req_ready = p1_ready;

  always_comb begin
    RW0_wmode = 1'b0;
    RW0_addr  = p0.req_addr;
    RW0_wdata = p0.req_wdata;
    if (state == INIT) begin
      RW0_wmode = 1'b1;
      RW0_addr  = init_cnt;
      RW0_wdata = '0;
    end else if (p0_fire) begin
      RW0_wmode = p0.req_wmode;
    end
  end

  always_comb begin
    RW1_wmode = p1_fire & p1.req_wmode;
    RW1_addr  = p1.req_addr;
    RW1_wdata = p1.req_wdata;
  end

  mem_rsp_slot #(.W(REG_WIDTH)) u_p0_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (p0_fire & ~p0.req_wmode),
    .load_data (RW0_rdata),
    .rsp_valid (p0_rsp_vld),
    .rsp_ready (p0.rsp_ready),
    .rsp_data  (p0_rsp_dat)
  );

  mem_rsp_slot #(.W(REG_WIDTH)) u_p1_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (p1_fire & ~p1.req_wmode),
    .load_data (RW1_rdata),
    .rsp_valid (p1_rsp_vld),
    .rsp_ready (p1.rsp_ready),
    .rsp_data  (p1_rsp_dat)
  );

  assign p0.rsp_valid = p0_rsp_vld;
  assign p0.rsp_rdata = p0_rsp_dat;
  assign p1.rsp_valid = p1_rsp_vld;
  assign p1.rsp_rdata = p1_rsp_dat;

endmodule
